tbcm_stream_merger: RTL and testbench
=====================================

TBCM_STREAM_MERGER -- requirements
Module: tbcm_stream_merger

Interface
REQ-001 Parameter INPUTS, default 2: number of input streams, at least 2.
REQ-002 Parameter WIDTH, default 8: data width per beat, at least 1.
REQ-003 The module SHALL use clk as its clock and rst_n as its reset (asynchronous, active-low).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  INPUTS  per-input beat valid.
REQ-007 o_ready  output  INPUTS  per-input beat accepted when paired with i_valid.
REQ-008 i_data  input  INPUTS x WIDTH  unpacked array of per-input data.
REQ-009 i_last  input  INPUTS  per-input last beat of packet.
REQ-010 o_valid  output  1  merged beat valid.
REQ-011 i_ready  input  1  downstream ready.
REQ-012 o_data  output  WIDTH  merged data.
REQ-013 o_last  output  1  merged last flag.
REQ-014 o_grant  output  INPUTS  one-hot owner of the current packet; zero when idle.

Function
REQ-015 An input beat is accepted when i_valid[k] and o_ready[k] are both 1; an output beat is accepted when o_valid and i_ready are both 1.
REQ-016 FSM states: IDLE (no owner) and LOCKED (owner held until its last beat).
REQ-017 In IDLE with any i_valid set, the block SHALL grant combinationally in the same cycle: first set i_valid scanning upward, with wrap-around, from index (pointer+1) mod INPUTS.
REQ-018 The pointer SHALL load the granted index whenever a grant is taken in IDLE; it resets to INPUTS-1, so the first search starts at input 0.
REQ-019 An IDLE grant whose first beat is not accepted that cycle, or is accepted with i_last=0, SHALL move the FSM to LOCKED with that owner.
REQ-020 A grant whose first beat is accepted with i_last=1 (single-beat packet) SHALL leave the FSM in IDLE.
REQ-021 In LOCKED, only the owner is eligible regardless of other i_valid; an accepted owner beat with i_last=1 SHALL return the FSM to IDLE at the next edge.
REQ-022 In LOCKED, owner i_valid=0 (a bubble) SHALL hold the lock; no other input may be granted.
REQ-023 o_ready[k] SHALL be 1 only for k equal to the granted/owner index and only when the output stage can accept a beat; all other bits are 0.
REQ-024 Beats SHALL be forwarded in order with no loss or duplication, and data/last SHALL stay paired.
REQ-025 o_grant SHALL be the one-hot of the IDLE-cycle grant or of the LOCKED owner; it is 0 in IDLE with no i_valid.

Reset
REQ-026 On rst_n low: FSM = IDLE, pointer = INPUTS-1, output stage empty, o_valid = 0, o_grant = 0, o_ready = 0.
REQ-027 Reset asserted mid-packet SHALL discard the lock and any buffered beats; after release, arbitration restarts from input 0.

Configuration
REQ-028 Macro TBCM_STREAM_MERGER_OUTPUT_SLICE_EN SHALL select the output stage.
REQ-029 With the macro defined, the output stage SHALL be a 2-entry skid buffer:
  - o_valid/o_data/o_last driven from registers; 1-cycle latency from input accept to o_valid.
  - Upstream readiness derived from a registered not-full flag, with no combinational path from i_ready to o_ready.
  - Full throughput of 1 beat per cycle when i_ready is held at 1.
REQ-030 Without the macro, the output stage SHALL be a pass-through:
  - o_valid = owner i_valid; o_data and o_last taken from the owner.
  - Upstream readiness = i_ready; zero latency.
  - With no grant, o_valid = 0 and o_data = 0.

Verification
REQ-031 INPUTS=4, WIDTH=8, i_ready=1: inputs 0 and 2 each send single-beat packets continuously -> grants alternate 0,2,0,2; input 0's 0x11 appears first.
REQ-032 Input 1 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last), input 3 is valid throughout, input 1 has a bubble after 0xA1 -> output is 0xA0, 0xA1, 0xA2 then 0x3x; o_grant stays 4'b0010 during the bubble.
REQ-033 Pointer wrap: last grant was input 3 and inputs 0 and 3 are both valid -> input 0 wins.
REQ-034 Slice enabled, i_ready low for 3 cycles mid-packet -> at most 2 beats buffered, o_ready[owner]=0 once full, and no data lost after i_ready returns to 1.
REQ-035 rst_n pulsed low during beat 2 of a 4-beat packet -> o_valid=0 and o_grant=0 during reset; afterwards a new request on input 2 with input 0 idle is granted immediately.
REQ-036 Both macro settings SHALL be simulated: latency is 1 cycle with the slice and 0 cycles without, with identical output beat sequences.

Source files
------------

// File: rtl/tbcm_stream_merger.sv
// tbcm_stream_merger
//   Packet-aware round-robin merger of INPUTS valid/ready streams into one.
//   An owner is picked combinationally while idle, starting after the last
//   granted index (with wrap-around). The owner is then held until its
//   last beat is accepted.
//
// Configuration:
//   TBCM_STREAM_MERGER_OUTPUT_SLICE_EN
//     defined   : output driven by a 2-entry skid buffer (1-cycle latency,
//                 no combinational path from i_ready to o_ready).
//     undefined : output is a pass-through of the owner (0-cycle latency).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_valid/o_ready per-input handshake
//   i_data, i_last  per-input payload (i_data is an unpacked array)
//   o_valid/i_ready merged output handshake
//   o_data, o_last  merged payload
//   o_grant         one-hot current owner, zero when idle with no request
module tbcm_stream_merger #(
    parameter int unsigned INPUTS = 2,
    parameter int unsigned WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] i_valid,
    output logic [INPUTS-1:0] o_ready,
    input  logic [WIDTH-1:0]  i_data [INPUTS],
    input  logic [INPUTS-1:0] i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_last,
    output logic [INPUTS-1:0] o_grant
);

    localparam int unsigned IdxW = $clog2(INPUTS);
    typedef logic [IdxW-1:0] idx_t;
    localparam logic [INPUTS-1:0] OneHotLsb = INPUTS'(1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e state_q, state_d;
    idx_t   ptr_q, ptr_d;
    idx_t   owner_q, owner_d;

    idx_t              cand;
    idx_t              scan_idx;
    logic              scan_any;
    idx_t              grant_idx;
    logic              grant_any;
    logic [INPUTS-1:0] grant_oh;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_last;
    logic              stage_ready;
    logic              accept;

    // Round-robin search starting at (ptr + 1) mod INPUTS.
    always_comb begin
        scan_any = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int unsigned j = 0; j < INPUTS; j++) begin
            cand = idx_t'((32'(ptr_q) + 32'd1 + j) % INPUTS);
            if (!scan_any && i_valid[cand]) begin
                scan_any = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // Grant is forced off while reset is asserted so no input sees a
    // ready or grant before the block is running.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = scan_idx;
        if (rst_n) begin
            if (state_q == StLocked) begin
                grant_any = 1'b1;
                grant_idx = owner_q;
            end else begin
                grant_any = scan_any;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_oh = grant_any ? (OneHotLsb << grant_idx) : '0;
    assign o_grant  = grant_oh;
    assign in_valid = grant_any & i_valid[grant_idx];
    assign in_data  = i_data[grant_idx];
    assign in_last  = i_last[grant_idx];
    assign o_ready  = stage_ready ? grant_oh : '0;
    assign accept   = in_valid & stage_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    ptr_d   = grant_idx;
                    owner_d = grant_idx;
                    // Single-beat packets never lock.
                    if (!(accept && in_last)) state_d = StLocked;
                end
            end
            StLocked: begin
                if (accept && in_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= idx_t'(INPUTS - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

`ifdef TBCM_STREAM_MERGER_OUTPUT_SLICE_EN
    logic [1:0]       cnt_q, cnt_d;
    logic             not_full_q;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             last0_q, last0_d, last1_q, last1_d;
    logic             pop;

    // Entry 0 is the head and drives the outputs directly.
    assign o_valid     = (cnt_q != 2'd0);
    assign o_data      = data0_q;
    assign o_last      = last0_q;
    assign stage_ready = not_full_q;
    assign pop         = o_valid & i_ready;

    always_comb begin
        cnt_d   = cnt_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        unique case ({accept, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data0_d = in_data;
                    last0_d = in_last;
                end else begin
                    data1_d = in_data;
                    last1_d = in_last;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    data0_d = in_data;
                    last0_d = in_last;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = in_data;
                    last1_d = in_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            not_full_q <= 1'b1;
            data0_q    <= '0;
            data1_q    <= '0;
            last0_q    <= 1'b0;
            last1_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            not_full_q <= (cnt_d != 2'd2);
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            last0_q    <= last0_d;
            last1_q    <= last1_d;
        end
    end
`else
    assign stage_ready = i_ready;
    assign o_valid     = in_valid;
    assign o_data      = grant_any ? in_data : '0;
    assign o_last      = grant_any ? in_last : 1'b0;
`endif

endmodule

// File: tb/tb_tbcm_stream_merger.sv
// Scoreboard bench for tbcm_stream_merger (INPUTS=4, WIDTH=8).
// Per-input source queues feed a driver process; directed tests push the
// hand-ordered expected beats into a scoreboard that a monitor drains.
module tb_tbcm_stream_merger;

    typedef struct packed {
        logic       bubble;
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_valid;
    logic [3:0] o_ready;
    logic [7:0] i_data [4];
    logic [3:0] i_last;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_last;
    logic [3:0] o_grant;

    beat_t src [4][$];
    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    int    rcv    = 0;
    exp_t  mon_e;
    beat_t drv_b;
    logic [3:0] acc;
    logic [3:0] bub = '0;
    logic  ok;

    tbcm_stream_merger #(
        .INPUTS(4),
        .WIDTH (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .i_last (i_last),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_last (o_last),
        .o_grant(o_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int k, input logic [7:0] d, input logic l);
        beat_t b;
        b.bubble = 1'b0;
        b.last   = l;
        b.data   = d;
        src[k].push_back(b);
    endtask

    task automatic push_bubble(input int k);
        beat_t b;
        b = '0;
        b.bubble = 1'b1;
        src[k].push_back(b);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l);
        exp_t e;
        e.last = l;
        e.data = d;
        sb.push_back(e);
    endtask

    // Waits (bounded) for all of mask to be presented; returns at that negedge.
    task automatic wait_valid(input logic [3:0] mask, input string name, output logic found);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if ((i_valid & mask) == mask) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: inputs 0x%0h never presented, required 0x%0h", name, i_valid, mask);
        end
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && src[0].size() == 0 && src[1].size() == 0 &&
                src[2].size() == 0 && src[3].size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: %0d beats still expected, required 0", name, sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Waits (bounded) until the monitor has seen a beat beyond base.
    task automatic wait_rcv(input int base, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk);
            #3;
            if (rcv > base) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: received %0d beats, required more than %0d", name, rcv, base);
        end
    endtask

    // Monitor: every accepted output beat is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h, required no beat", o_data);
            end else begin
                mon_e = sb.pop_front();
                check("beat_data", {24'd0, o_data}, {24'd0, mon_e.data});
                check("beat_last", {31'd0, o_last}, {31'd0, mon_e.last});
            end
            rcv++;
        end
    end

    // Driver: retires accepted beats and bubbles, then presents each queue head.
    initial begin
        i_valid = '0;
        i_last  = '0;
        for (int k = 0; k < 4; k++) i_data[k] = '0;
        forever begin
            @(negedge clk);
            acc = i_valid & o_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if ((acc[k] || bub[k]) && src[k].size() > 0) void'(src[k].pop_front());
                if (src[k].size() > 0) begin
                    drv_b      = src[k][0];
                    i_valid[k] = !drv_b.bubble;
                    i_data[k]  = drv_b.data;
                    i_last[k]  = drv_b.last;
                    bub[k]     = drv_b.bubble;
                end else begin
                    i_valid[k] = 1'b0;
                    i_data[k]  = '0;
                    i_last[k]  = 1'b0;
                    bub[k]     = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n   = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_o_valid", {31'd0, o_valid}, 32'd0);
        check("reset_o_grant", {28'd0, o_grant}, 32'd0);
        check("reset_o_ready", {28'd0, o_ready}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Alternating single-beat packets from inputs 0 and 2.
        @(negedge clk);
        push_beat(0, 8'h11, 1'b1); push_beat(0, 8'h12, 1'b1);
        push_beat(0, 8'h13, 1'b1); push_beat(0, 8'h14, 1'b1);
        push_beat(2, 8'h21, 1'b1); push_beat(2, 8'h22, 1'b1); push_beat(2, 8'h23, 1'b1);
        expect_beat(8'h11, 1'b1); expect_beat(8'h21, 1'b1); expect_beat(8'h12, 1'b1);
        expect_beat(8'h22, 1'b1); expect_beat(8'h13, 1'b1); expect_beat(8'h23, 1'b1);
        expect_beat(8'h14, 1'b1);
        wait_valid(4'b0101, "alt_start", ok);
        if (ok) begin
            check("alt_grant0", {28'd0, o_grant}, 32'h1);
            check("alt_ready0", {28'd0, o_ready}, 32'h1);
`ifdef TBCM_STREAM_MERGER_OUTPUT_SLICE_EN
            check("latency_slice", {31'd0, o_valid}, 32'd0);
`else
            check("latency_pass", {31'd0, o_valid}, 32'd1);
            check("latency_pass_data", {24'd0, o_data}, 32'h11);
`endif
            @(negedge clk);
            check("alt_grant2", {28'd0, o_grant}, 32'h4);
        end
        wait_drain("alt_drain");

        // Multi-beat packet with a bubble; input 3 must wait for the last beat.
        @(negedge clk);
        push_beat(1, 8'hA0, 1'b0); push_beat(1, 8'hA1, 1'b0);
        push_bubble(1);            push_beat(1, 8'hA2, 1'b1);
        push_beat(3, 8'h31, 1'b1);
        expect_beat(8'hA0, 1'b0); expect_beat(8'hA1, 1'b0);
        expect_beat(8'hA2, 1'b1); expect_beat(8'h31, 1'b1);
        wait_valid(4'b1010, "lock_start", ok);
        if (ok) check("lock_grant", {28'd0, o_grant}, 32'h2);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (!i_valid[1] && i_valid[3]) ok = 1'b1;
            else @(negedge clk);
        end
        check("bubble_seen", {31'd0, ok}, 32'd1);
        if (ok) begin
            check("bubble_grant", {28'd0, o_grant}, 32'h2);
            check("bubble_ready3", {31'd0, o_ready[3]}, 32'd0);
        end
        wait_drain("lock_drain");

        // Pointer wrap: last grant was 3, inputs 0 and 3 request.
        @(negedge clk);
        push_beat(0, 8'h15, 1'b1); push_beat(3, 8'h32, 1'b1);
        expect_beat(8'h15, 1'b1); expect_beat(8'h32, 1'b1);
        wait_valid(4'b1001, "wrap_start", ok);
        if (ok) check("wrap_grant", {28'd0, o_grant}, 32'h1);
        wait_drain("wrap_drain");

        // Downstream stall for 3 cycles mid-packet.
        @(negedge clk);
        base = rcv;
        push_beat(2, 8'h41, 1'b0); push_beat(2, 8'h42, 1'b0);
        push_beat(2, 8'h43, 1'b0); push_beat(2, 8'h44, 1'b1);
        expect_beat(8'h41, 1'b0); expect_beat(8'h42, 1'b0);
        expect_beat(8'h43, 1'b0); expect_beat(8'h44, 1'b1);
        wait_rcv(base, "stall_first");
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_ready", {28'd0, o_ready}, 32'h0);
        check("stall_grant", {28'd0, o_grant}, 32'h4);
        check("stall_valid", {31'd0, o_valid}, 32'd1);
        @(posedge clk);
        #3 i_ready = 1'b1;
        wait_drain("stall_drain");

        // Reset during beat 2 of a 4-beat packet.
        @(negedge clk);
        base = rcv;
        push_beat(1, 8'h51, 1'b0); push_beat(1, 8'h52, 1'b0);
        push_beat(1, 8'h53, 1'b0); push_beat(1, 8'h54, 1'b1);
        expect_beat(8'h51, 1'b0);
        wait_rcv(base, "rst_first");
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_o_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_o_grant", {28'd0, o_grant}, 32'h0);
        check("midrst_o_ready", {28'd0, o_ready}, 32'h0);
        src[1].delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_drain("rst_drain");

        // Arbitration restarts from input 0 after reset.
        @(negedge clk);
        push_beat(0, 8'h72, 1'b1); push_beat(3, 8'h35, 1'b1);
        expect_beat(8'h72, 1'b1); expect_beat(8'h35, 1'b1);
        wait_valid(4'b1001, "restart_start", ok);
        if (ok) check("restart_grant", {28'd0, o_grant}, 32'h1);
        wait_drain("restart_drain");

        // Lone request on input 2 is granted in the same cycle.
        @(negedge clk);
        push_beat(2, 8'h61, 1'b1);
        expect_beat(8'h61, 1'b1);
        wait_valid(4'b0100, "single_start", ok);
        if (ok) begin
            check("single_grant", {28'd0, o_grant}, 32'h4);
            check("single_ready", {28'd0, o_ready}, 32'h4);
        end
        wait_drain("single_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
